// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register load arbiter: FSM state encoding and
// default requester count / data width.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ACK  = 2'b10
  } arb_state_e;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// searching upward from (ptr + 1) modulo NREQ, wrapping back to ptr itself.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IW = $clog2(NREQ);

  // Scan NREQ positions starting one past the last winner; first hit wins.
  always_comb begin
    int idx;
    valid = 1'b0;
    index = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        index = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one load-strobed register among NREQ requesters.
// Each transaction: latch winner's data, pulse load_n low for one cycle, then
// pulse the winner's ack for one cycle. All strobes come straight from flops.
// Optional feature macro LOAD_ARB_LOCK_EN: adds the lock port, letting the
// current owner reload back-to-back (ACK -> LOAD) without re-arbitration.
//
//  state | meaning
//  IDLE  | waiting for any request; winner picked and data latched on exit
//  LOAD  | load_n low, register captures reg_data at the closing edge
//  ACK   | ack to the winner; RR pointer advances when returning to IDLE
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
`ifdef LOAD_ARB_LOCK_EN
  input  logic [NREQ-1:0]         lock,
`endif
  output logic [NREQ-1:0]         ack,
  output logic                    load_n,
  output logic [DW-1:0]           reg_data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            load_n_q, load_n_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Next state plus next values of the registered strobes and data latch.
  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    load_n_d = 1'b1;
    ack_d    = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = LOAD;
          gid_d    = pick_idx;
          data_d   = req_data[int'(pick_idx)*DW +: DW];
          load_n_d = 1'b0;
        end
      end
      LOAD: begin
        state_d       = ACK;
        ack_d[gid_q]  = 1'b1;
      end
      ACK: begin
`ifdef LOAD_ARB_LOCK_EN
        if (lock[gid_q] && req[gid_q]) begin
          // Owner keeps the register; pointer stays put until lock releases.
          state_d  = LOAD;
          data_d   = req_data[int'(gid_q)*DW +: DW];
          load_n_d = 1'b0;
        end else begin
          state_d = IDLE;
          ptr_d   = gid_q;
        end
`else
        state_d = IDLE;
        ptr_d   = gid_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, data latch and output strobes with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gid_q    <= '0;
      ptr_q    <= IW'(NREQ - 1);
      data_q   <= '0;
      load_n_q <= 1'b1;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      load_n_q <= load_n_d;
      ack_q    <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign load_n   = load_n_q;
  assign reg_data = data_q;
  assign grant_id = gid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter: directed per-cycle vector table, a lock
// sequence when the lock feature is built in, and a randomized run checked
// against a transaction-level model (each grant schedules its 3-cycle output
// pattern into a queue).
module tb_reg_load_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  lock;
  logic [N-1:0]  ack;
  logic          load_n;
  logic [DW-1:0] reg_data;
  logic [1:0]    grant_id;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         ln;
    logic [N-1:0] ack;
    logic         busy;
    logic [DW-1:0] rd;
    logic [1:0]   gid;
  } exp_t;

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] data;
    exp_t          e;
  } vec_t;

  vec_t vecs[$];
  exp_t sched[$];

  reg_load_arbiter #(.NREQ(N), .DW(DW)) dut (
    .clk      (clk),
`ifdef LOAD_ARB_LOCK_EN
    .lock     (lock),
`endif
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .load_n   (load_n),
    .reg_data (reg_data),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic ln, logic [N-1:0] a, logic b, logic [DW-1:0] rd, logic [1:0] g);
    exp_t e;
    e.ln = ln; e.ack = a; e.busy = b; e.rd = rd; e.gid = g;
    return e;
  endfunction

  function automatic void add(logic rst, logic [N-1:0] r, logic [N*DW-1:0] d,
                              logic ln, logic [N-1:0] a, logic b, logic [DW-1:0] rd, logic [1:0] g);
    vec_t v;
    v.rst = rst; v.req = r; v.data = d; v.e = mk(ln, a, b, rd, g);
    vecs.push_back(v);
  endfunction

  task automatic check(string name, exp_t e);
    checks++;
    if (load_n !== e.ln || ack !== e.ack || busy !== e.busy ||
        reg_data !== e.rd || grant_id !== e.gid) begin
      errors++;
      $display("FAIL %s t=%0t: got ln=%b ack=%b busy=%b rd=%h gid=%0d, want ln=%b ack=%b busy=%b rd=%h gid=%0d",
               name, $time, load_n, ack, busy, reg_data, grant_id,
               e.ln, e.ack, e.busy, e.rd, e.gid);
    end
  endtask

  // Drive at the falling edge, check just after the next rising edge.
  task automatic step(logic rst, logic [N-1:0] r, logic [N*DW-1:0] d, logic [N-1:0] lk);
    @(negedge clk);
    reset = rst; req = r; req_data = d; lock = lk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int m_last, m_gid, w;
    logic [DW-1:0] m_data;
    exp_t e;
    logic rst_r;
    logic [N-1:0] req_r;
    logic [N*DW-1:0] data_r;

    reset = 1'b1; req = '0; req_data = '0; lock = '0;

    // Single request from requester 0, data 2.
    add(1, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 0);
    add(0, 4'b0001, 16'h0002, 0, 4'b0000, 1, 4'h2, 0);
    add(0, 4'b0001, 16'h0002, 1, 4'b0001, 1, 4'h2, 0);
    add(0, 4'b0000, 16'h0002, 1, 4'b0000, 0, 4'h2, 0);
    // All four requesting: 0,1,2,3,0 three cycles apart.
    add(1, 4'b1111, 16'h4321, 1, 4'b0000, 0, 4'h0, 0);
    add(0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'h1, 0);
    add(0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'h1, 0);
    add(0, 4'b1111, 16'h4321, 1, 4'b0000, 0, 4'h1, 0);
    add(0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'h2, 1);
    add(0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 4'h2, 1);
    add(0, 4'b1111, 16'h4321, 1, 4'b0000, 0, 4'h2, 1);
    add(0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'h3, 2);
    add(0, 4'b1111, 16'h4321, 1, 4'b0100, 1, 4'h3, 2);
    add(0, 4'b1111, 16'h4321, 1, 4'b0000, 0, 4'h3, 2);
    add(0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'h4, 3);
    add(0, 4'b1111, 16'h4321, 1, 4'b1000, 1, 4'h4, 3);
    add(0, 4'b1111, 16'h4321, 1, 4'b0000, 0, 4'h4, 3);
    add(0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'h1, 0);
    add(0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'h1, 0);
    add(0, 4'b0000, 16'h4321, 1, 4'b0000, 0, 4'h1, 0);
    // Grant 2, then 4'b0101 wraps to 0 before 2 again.
    add(0, 4'b0100, 16'h4321, 0, 4'b0000, 1, 4'h3, 2);
    add(0, 4'b0100, 16'h4321, 1, 4'b0100, 1, 4'h3, 2);
    add(0, 4'b0101, 16'h4321, 1, 4'b0000, 0, 4'h3, 2);
    add(0, 4'b0101, 16'h4321, 0, 4'b0000, 1, 4'h1, 0);
    add(0, 4'b0101, 16'h4321, 1, 4'b0001, 1, 4'h1, 0);
    add(0, 4'b0100, 16'h4321, 1, 4'b0000, 0, 4'h1, 0);
    add(0, 4'b0100, 16'h4321, 0, 4'b0000, 1, 4'h3, 2);
    add(0, 4'b0100, 16'h4321, 1, 4'b0100, 1, 4'h3, 2);
    add(0, 4'b0000, 16'h4321, 1, 4'b0000, 0, 4'h3, 2);
    // Reset during LOAD of data 5: no ack afterwards.
    add(0, 4'b0010, 16'h0050, 0, 4'b0000, 1, 4'h5, 1);
    add(1, 4'b0000, 16'h0050, 1, 4'b0000, 0, 4'h0, 0);
    add(0, 4'b0000, 16'h0050, 1, 4'b0000, 0, 4'h0, 0);
    add(0, 4'b0000, 16'h0050, 1, 4'b0000, 0, 4'h0, 0);
    // Requester 1 arrives while 0 is busy; served right after.
    add(0, 4'b0001, 16'h0053, 0, 4'b0000, 1, 4'h3, 0);
    add(0, 4'b0011, 16'h0053, 1, 4'b0001, 1, 4'h3, 0);
    add(0, 4'b0010, 16'h0053, 1, 4'b0000, 0, 4'h3, 0);
    add(0, 4'b0010, 16'h0053, 0, 4'b0000, 1, 4'h5, 1);
    add(0, 4'b0010, 16'h0053, 1, 4'b0010, 1, 4'h5, 1);
    add(0, 4'b0000, 16'h0053, 1, 4'b0000, 0, 4'h5, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].data, '0);
      check($sformatf("vec%0d", i), vecs[i].e);
    end

`ifdef LOAD_ARB_LOCK_EN
    // Locked owner 3 reloads every 2 cycles; 0 wins once the lock drops.
    step(1, 4'b0000, 16'h9001, 4'b0000);
    check("lock_rst", mk(1, 4'b0000, 0, 4'h0, 0));
    step(0, 4'b1000, 16'h9001, 4'b1000);
    check("lock_load0", mk(0, 4'b0000, 1, 4'h9, 3));
    for (int k = 2; k <= 6; k++) begin
      step(0, 4'b1001, 16'h9001, 4'b1000);
      if (k % 2 == 0) check($sformatf("lock_ack%0d", k), mk(1, 4'b1000, 1, 4'h9, 3));
      else            check($sformatf("lock_load%0d", k), mk(0, 4'b0000, 1, 4'h9, 3));
    end
    step(0, 4'b0001, 16'h9001, 4'b0000);
    check("unlock_idle", mk(1, 4'b0000, 0, 4'h9, 3));
    step(0, 4'b0001, 16'h9001, 4'b0000);
    check("unlock_load0", mk(0, 4'b0000, 1, 4'h1, 0));
    step(0, 4'b0000, 16'h9001, 4'b0000);
    check("unlock_ack0", mk(1, 4'b0001, 1, 4'h1, 0));
`endif

    // Randomized run against the transaction-level model.
    m_last = N - 1; m_gid = 0; m_data = '0;
    sched.delete();
    for (int c = 0; c < 3000; c++) begin
      rst_r  = (c == 0) || ($urandom_range(0, 59) == 0);
      req_r  = N'($urandom & $urandom);
      data_r = (N*DW)'($urandom);
      @(negedge clk);
      reset = rst_r; req = req_r; req_data = data_r; lock = '0;
      @(posedge clk);
      if (rst_r) begin
        sched.delete();
        m_last = N - 1; m_gid = 0; m_data = '0;
        e = mk(1, '0, 0, '0, 0);
      end else begin
        if (sched.size() == 0 && req_r != 0) begin
          w = -1;
          for (int k = 1; k <= N; k++)
            if (w < 0 && req_r[(m_last + k) % N]) w = (m_last + k) % N;
          m_gid  = w;
          m_data = data_r[w*DW +: DW];
          m_last = w;
          sched.push_back(mk(0, '0, 1, m_data, 2'(w)));
          sched.push_back(mk(1, N'(1) << w, 1, m_data, 2'(w)));
          sched.push_back(mk(1, '0, 0, m_data, 2'(w)));
        end
        if (sched.size() != 0) e = sched.pop_front();
        else e = mk(1, '0, 0, m_data, 2'(m_gid));
      end
      #1;
      check($sformatf("rand%0d", c), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

Shares one 4-bit load-strobed register between several requesters. Each requester presents data and raises a request. The arbiter picks one requester round-robin and drives the register's data input with that requester's data. It then pulses the register's active-low load line for one cycle and acknowledges the winner. It sits between the control-unit sources that write a common register and the register itself, whose load line is sampled on the rising clock edge.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 4, register data width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  request per requester, level
- req_data  input  NREQ*DW  requester data; slice i is bits [i*DW +: DW]
- lock  input  NREQ  keep ownership for back-to-back loads; present only with LOAD_ARB_LOCK_EN
- ack  output  NREQ  one-cycle pulse to the requester whose data was loaded
- load_n  output  1  active-low load strobe to the register
- reg_data  output  DW  data to the register input
- grant_id  output  $clog2(NREQ)  index of the current or last winner
- busy  output  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, LOAD, ACK.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise choose the first set req bit searching upward from (last winner + 1) modulo NREQ. Register it in grant_id, latch req_data[grant_id] into reg_data, and go to LOAD.
- LOAD:
  - load_n = 0 for exactly this cycle; reg_data is held.
  - The register captures reg_data at the clock edge that ends LOAD.
  - Always go to ACK.
- ACK:
  - ack[grant_id] = 1 for exactly this cycle; load_n = 1.
  - Update the round-robin pointer to grant_id.
  - Go to IDLE, except for the lock case in Configuration.
- req is sampled only in IDLE, or in ACK when lock is enabled.
  - A requester must drop req in its ACK cycle. If req is still high after ACK, it counts as a new request.
  - req_data[i] must be stable from req[i] rising until ack[i].
- A req that drops before it is granted is simply not served; no error is flagged.
- Requests that arrive while busy wait; none are lost while req is held.
- Reset values: load_n=1, reg_data=0, ack=0, grant_id=0, busy=0, state=IDLE, RR pointer=NREQ-1 so that requester 0 wins first.
- Reset asserted mid-operation:
  - Return to IDLE at that edge.
  - If the state was LOAD, load_n is already high in the next cycle; the register has captured the data on that edge.
  - No ack is issued for the aborted transaction.

## Timing
- The winner is decided in the cycle where req is seen in IDLE (cycle 0).
- Cycle 1 is LOAD: load_n is low.
- The register output shows the new value after the edge ending cycle 1.
- Cycle 2 is ACK: ack is high. Cycle 3 is IDLE.
- Throughput: one load per 3 cycles, or per 2 cycles under lock.
- Exactly one ack bit is ever high at a time. load_n and ack are never active in the same cycle.
- All outputs are registered; there is no combinational path from req to load_n or ack.

## Configuration
- LOAD_ARB_LOCK_EN defined:
  - The lock port exists.
  - In ACK, if lock[grant_id] and req[grant_id] are both high, go straight to LOAD with the same grant_id and relatch req_data[grant_id].
  - The RR pointer is not advanced until the lock is released.
- LOAD_ARB_LOCK_EN undefined: the lock port is absent and ACK always returns to IDLE.

## Structure
- Shared package reg_arb_pkg holds:
  - the state encoding: IDLE=2'b00, LOAD=2'b01, ACK=2'b10;
  - default NREQ and DW constants.
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: req, pointer.
  - Outputs: valid, index.
- The top level holds the FSM, data latch and pointer.

## Test plan
- Reset, then req=4'b0001 with data0=4'h2 → load_n low in cycle 1, register reads 4'h2, ack=4'b0001 in cycle 2, busy low in cycle 3.
- req=4'b1111 held with data 1,2,3,4 → grants in order 0,1,2,3,0, each 3 cycles apart; register reads 1,2,3,4.
- After granting 2, req=4'b0101 → next grant is 0 (wrap-around), then 2.
- Reset asserted during LOAD with data 4'h5 → next cycle load_n=1, state IDLE, no ack pulse, grant_id=0.
- req[1] rises while a load for 0 is busy, data1=4'h5 → it is served right after the ACK for 0; register reads 4'h5.
- With LOAD_ARB_LOCK_EN: lock[3]=1, req[3] held, req[0] also high → requester 3 is reloaded every 2 cycles; requester 0 is granted within 3 cycles of lock[3] dropping.
